// File: rtl/intrp_arbiter.sv
// Interrupt concentrator: latches one pending interrupt per channel and forwards
// them round-robin over a single req/ack channel with ack timeout supervision.
module intrp_arbiter #(
  parameter int N_CH    = 4,
  parameter int SRC_W   = 64,
  parameter int CTX_W   = 9,
  parameter int TMO_CYC = 1024,
  parameter int CNT_W   = 32
) (
  input  logic                   action_clock,
  input  logic                   action_rst,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH*SRC_W-1:0]  ch_src,
  input  logic [N_CH*CTX_W-1:0]  ch_ctx,
  input  logic [N_CH-1:0]        ch_en,
  output logic [N_CH-1:0]        ch_busy,
  output logic [N_CH-1:0]        ch_done,
  output logic [N_CH-1:0]        ch_drop,
  output logic                   intrp_req,
  input  logic                   intrp_ack,
  output logic [SRC_W-1:0]       intrp_src,
  output logic [CTX_W-1:0]       intrp_ctx,
  output logic                   err_timeout,
  output logic                   err_spurious,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       done_cnt
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TMO_CYC > 0) ? TMO_W'(TMO_CYC - 1) : '0;
  localparam logic [PTR_W:0]   N_CH_W   = (PTR_W + 1)'(N_CH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state;
  logic [N_CH-1:0]    pending;
  logic [SRC_W-1:0]   slot_src [N_CH];
  logic [CTX_W-1:0]   slot_ctx [N_CH];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win;
  logic [TMO_W-1:0]   timer;

  logic               ack_hit;
  logic               tmo_hit;
  logic [N_CH-1:0]    ack_clr;
  logic [N_CH-1:0]    capture;
  logic [N_CH-1:0]    drop;
  logic [N_CH-1:0]    cand;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W:0]     idx;
  logic [PTR_W:0]     win_inc;
  logic [PTR_W-1:0]   rr_next;

  assign ch_busy = pending;
  assign ack_hit = (state == REQ) && intrp_ack;
  // Ack has priority: a timeout only counts when no ack arrives that cycle.
  assign tmo_hit = (TMO_CYC > 0) && (state == REQ) && !intrp_ack && (timer == TMO_LAST);
  assign cand    = pending & ch_en;

  // A channel freed by ack this cycle can accept a new request in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ack_clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      ack_clr[i] = ack_hit && (win == PTR_W'(i));
    end
    capture = ch_req & (~pending | ack_clr);
    drop    = ch_req & pending & ~ack_clr;
  end

  // Round-robin search: first enabled pending channel at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (idx >= N_CH_W) idx = idx - N_CH_W;
      if (!found && cand[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_inc = {1'b0, win} + (PTR_W + 1)'(1);
    rr_next = (win_inc >= N_CH_W) ? '0 : win_inc[PTR_W-1:0];
  end

  // NOTE: slot storage has no reset; a slot is only read after pending is set,
  // which always coincides with a write to that slot.
  always_ff @(posedge action_clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (capture[i]) begin
        slot_src[i] <= ch_src[i*SRC_W +: SRC_W];
        slot_ctx[i] <= ch_ctx[i*CTX_W +: CTX_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge action_clock or posedge action_rst) begin
    if (action_rst) begin
      state        <= IDLE;
      pending      <= '0;
      ch_done      <= '0;
      ch_drop      <= '0;
      intrp_req    <= 1'b0;
      intrp_src    <= '0;
      intrp_ctx    <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      done_cnt     <= '0;
      rr_ptr       <= '0;
      win          <= '0;
      timer        <= '0;
    end else begin
      pending      <= (pending & ~ack_clr) | capture;
      ch_done      <= ack_clr;
      ch_drop      <= drop;
      // A new error in the clear cycle keeps the flag set.
      err_spurious <= (err_spurious & ~err_clr) | ((state == IDLE) && intrp_ack);
      err_timeout  <= (err_timeout & ~err_clr) | tmo_hit;

      case (state)
        IDLE: begin
          if (found) begin
            win       <= pick;
            intrp_src <= slot_src[pick];
            intrp_ctx <= slot_ctx[pick];
            intrp_req <= 1'b1;
            timer     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_hit) begin
            intrp_req <= 1'b0;
            done_cnt  <= done_cnt + CNT_W'(1);
            rr_ptr    <= rr_next;
            state     <= IDLE;
          end else if (tmo_hit) begin
            intrp_req <= 1'b0;
            rr_ptr    <= rr_next;
            state     <= IDLE;
          end else begin
            timer <= timer + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intrp_arbiter.sv
// Directed bench for intrp_arbiter: a cycle table for round-robin/drop/recapture
// plus hand-written sequences for single grant, timeout, masking, wrap and reset.
module tb_intrp_arbiter;

  localparam int N_CH = 4, SRC_W = 64, CTX_W = 9, TMO_CYC = 16, CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       ch_req, ch_en, ch_busy, ch_done, ch_drop;
  logic [N_CH*SRC_W-1:0] ch_src;
  logic [N_CH*CTX_W-1:0] ch_ctx;
  logic                  intrp_req, intrp_ack, err_timeout, err_spurious, err_clr;
  logic [SRC_W-1:0]      intrp_src;
  logic [CTX_W-1:0]      intrp_ctx;
  logic [CNT_W-1:0]      done_cnt;

  logic [SRC_W-1:0]      drv_src [N_CH];
  logic [CTX_W-1:0]      drv_ctx [N_CH];

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  intrp_arbiter #(.N_CH(N_CH), .SRC_W(SRC_W), .CTX_W(CTX_W), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W)) dut (
    .action_clock(clk), .action_rst(rst),
    .ch_req(ch_req), .ch_src(ch_src), .ch_ctx(ch_ctx), .ch_en(ch_en),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_drop(ch_drop),
    .intrp_req(intrp_req), .intrp_ack(intrp_ack),
    .intrp_src(intrp_src), .intrp_ctx(intrp_ctx),
    .err_timeout(err_timeout), .err_spurious(err_spurious), .err_clr(err_clr),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_src = '0;
    ch_ctx = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_src[i*SRC_W +: SRC_W] = drv_src[i];
      ch_ctx[i*CTX_W +: CTX_W] = drv_ctx[i];
    end
  end

  function automatic logic [SRC_W-1:0] src_of(int ch, logic alt);
    return {32'hC0DE_0000 | 32'(ch), alt ? 32'h5A5A_5A5A : 32'h0000_1111};
  endfunction

  function automatic logic [CTX_W-1:0] ctx_of(int ch, logic alt);
    return CTX_W'(ch * 8 + (alt ? 100 : 1));
  endfunction

  task automatic set_data(input logic alt);
    for (int i = 0; i < N_CH; i++) begin
      drv_src[i] = src_of(i, alt);
      drv_ctx[i] = ctx_of(i, alt);
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!intrp_req && n < 20) begin
      step();
      n++;
    end
    check("wait_req", intrp_req, 1'b1);
  endtask

  task automatic grant_ack(input int ch);
    ch_req = 4'(1 << ch);
    step();
    ch_req = '0;
    wait_req();
    intrp_ack = 1'b1;
    step();
    intrp_ack = 1'b0;
    exp_cnt++;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       alt;
    logic       ack;
    logic       exp_req;
    int         exp_ch;
    logic       exp_alt;
    logic [3:0] exp_busy;
    logic [3:0] exp_done;
    logic [3:0] exp_drop;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(logic [3:0] req, logic alt, logic ack, logic er, int ch, logic ea,
                              logic [3:0] busy, logic [3:0] done, logic [3:0] drp, logic [3:0] cnt);
    vec_t v;
    v.req = req; v.alt = alt; v.ack = ack; v.exp_req = er; v.exp_ch = ch; v.exp_alt = ea;
    v.exp_busy = busy; v.exp_done = done; v.exp_drop = drp; v.exp_cnt = cnt;
    return v;
  endfunction

  initial begin
    int n;
    // Inputs held during one cycle; expectations are what is visible after that edge.
    vecs[0]  = mk(4'b1111, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    vecs[1]  = mk(4'b0000, 0, 0, 1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    vecs[2]  = mk(4'b0000, 0, 1, 0, 0, 0, 4'b1110, 4'b0001, 4'b0000, 1);
    vecs[3]  = mk(4'b0000, 0, 0, 1, 1, 0, 4'b1110, 4'b0000, 4'b0000, 1);
    vecs[4]  = mk(4'b0000, 0, 1, 0, 0, 0, 4'b1100, 4'b0010, 4'b0000, 2);
    vecs[5]  = mk(4'b0000, 0, 0, 1, 2, 0, 4'b1100, 4'b0000, 4'b0000, 2);
    vecs[6]  = mk(4'b0000, 0, 1, 0, 0, 0, 4'b1000, 4'b0100, 4'b0000, 3);
    vecs[7]  = mk(4'b0000, 0, 0, 1, 3, 0, 4'b1000, 4'b0000, 4'b0000, 3);
    vecs[8]  = mk(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4);
    vecs[9]  = mk(4'b1001, 0, 0, 0, 0, 0, 4'b1001, 4'b0000, 4'b0000, 4);
    vecs[10] = mk(4'b0000, 0, 0, 1, 0, 0, 4'b1001, 4'b0000, 4'b0000, 4);
    vecs[11] = mk(4'b0000, 0, 1, 0, 0, 0, 4'b1000, 4'b0001, 4'b0000, 5);
    vecs[12] = mk(4'b0000, 0, 0, 1, 3, 0, 4'b1000, 4'b0000, 4'b0000, 5);
    vecs[13] = mk(4'b0010, 0, 0, 1, 3, 0, 4'b1010, 4'b0000, 4'b0000, 5);
    vecs[14] = mk(4'b0010, 1, 0, 1, 3, 0, 4'b1010, 4'b0000, 4'b0010, 5);
    vecs[15] = mk(4'b0000, 0, 1, 0, 0, 0, 4'b0010, 4'b1000, 4'b0000, 6);
    vecs[16] = mk(4'b0000, 0, 0, 1, 1, 0, 4'b0010, 4'b0000, 4'b0000, 6);
    vecs[17] = mk(4'b0010, 1, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 7);
    vecs[18] = mk(4'b0000, 0, 0, 1, 1, 1, 4'b0010, 4'b0000, 4'b0000, 7);
    vecs[19] = mk(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 8);
    vecs[20] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8);

    rst = 1'b1; ch_req = '0; ch_en = 4'hF; intrp_ack = 1'b0; err_clr = 1'b0;
    set_data(1'b0);
    step(); step();
    rst = 1'b0;
    step();
    check("reset_req", intrp_req, 1'b0);
    check("reset_busy", ch_busy, 4'b0);
    check("reset_pulses", {ch_done, ch_drop}, 8'b0);
    check("reset_err", {err_timeout, err_spurious}, 2'b0);
    check("reset_cnt", done_cnt, 4'd0);
    check("reset_src", {intrp_src, 7'b0, intrp_ctx}, 80'b0);

    // Round robin, drop, frozen data and same-cycle recapture
    for (int k = 0; k < 21; k++) begin
      ch_req = vecs[k].req;
      intrp_ack = vecs[k].ack;
      set_data(vecs[k].alt);
      step();
      check($sformatf("vec%0d_req", k), intrp_req, vecs[k].exp_req);
      check($sformatf("vec%0d_busy", k), ch_busy, vecs[k].exp_busy);
      check($sformatf("vec%0d_done", k), ch_done, vecs[k].exp_done);
      check($sformatf("vec%0d_drop", k), ch_drop, vecs[k].exp_drop);
      check($sformatf("vec%0d_cnt", k), done_cnt, vecs[k].exp_cnt);
      if (vecs[k].exp_req) begin
        check($sformatf("vec%0d_src", k), intrp_src, src_of(vecs[k].exp_ch, vecs[k].exp_alt));
        check($sformatf("vec%0d_ctx", k), intrp_ctx, ctx_of(vecs[k].exp_ch, vecs[k].exp_alt));
      end
    end
    ch_req = '0; intrp_ack = 1'b0; set_data(1'b0);
    exp_cnt = 4'd8;

    // Single request on channel 2: two-cycle latency, ack three cycles later
    drv_src[2] = 64'hDEAD_BEEF; drv_ctx[2] = 9'h1A5;
    ch_req = 4'b0100;
    step();
    ch_req = '0;
    drv_src[2] = '0; drv_ctx[2] = '0;
    check("single_n1_req", intrp_req, 1'b0);
    check("single_n1_busy", ch_busy, 4'b0100);
    step();
    check("single_n2_req", intrp_req, 1'b1);
    check("single_src", intrp_src, 64'hDEAD_BEEF);
    check("single_ctx", intrp_ctx, 9'h1A5);
    step(); step();
    check("single_hold", {intrp_req, intrp_ctx}, {1'b1, 9'h1A5});
    intrp_ack = 1'b1;
    step();
    intrp_ack = 1'b0;
    exp_cnt++;
    check("single_ack_req", intrp_req, 1'b0);
    check("single_done", ch_done, 4'b0100);
    check("single_busy", ch_busy, 4'b0000);
    check("single_cnt", done_cnt, exp_cnt);
    step();
    check("single_done_pulse", ch_done, 4'b0000);
    set_data(1'b0);

    // Timeout on channel 0 with channel 1 waiting
    ch_req = 4'b0011;
    step();
    ch_req = '0;
    check("tmo_busy", ch_busy, 4'b0011);
    step();
    check("tmo_grant0", intrp_src, src_of(0, 0));
    n = 0;
    while (intrp_req && n < 40) begin
      step();
      n++;
    end
    check("tmo_cycles", n, 16);
    check("tmo_err", err_timeout, 1'b1);
    check("tmo_busy_kept", ch_busy, 4'b0011);
    check("tmo_no_done", ch_done, 4'b0000);
    step();
    check("tmo_next_req", intrp_req, 1'b1);
    check("tmo_next_src", intrp_src, src_of(1, 0));
    intrp_ack = 1'b1;
    step();
    intrp_ack = 1'b0;
    exp_cnt++;
    check("tmo_done1", ch_done, 4'b0010);
    step();
    check("tmo_regrant0", intrp_src, src_of(0, 0));
    intrp_ack = 1'b1;
    step();
    intrp_ack = 1'b0;
    exp_cnt++;
    check("tmo_done0", ch_done, 4'b0001);
    check("tmo_cnt", done_cnt, exp_cnt);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("tmo_clr", err_timeout, 1'b0);

    // Masked channel latches but is not granted until enabled
    ch_en = 4'b1110;
    ch_req = 4'b0001;
    step();
    ch_req = '0;
    check("mask_busy", ch_busy, 4'b0001);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (intrp_req) n++;
    end
    check("mask_no_req", n, 0);
    ch_en = 4'b1111;
    step();
    check("mask_grant", {intrp_req, intrp_ctx}, {1'b1, ctx_of(0, 0)});
    ch_en = 4'b0000;
    step();
    check("mask_no_revoke", intrp_req, 1'b1);
    ch_en = 4'b1111;
    intrp_ack = 1'b1;
    step();
    exp_cnt++;
    check("mask_done", ch_done, 4'b0001);
    // intrp_req is low now, so this ack is spurious
    step();
    intrp_ack = 1'b0;
    check("spur_err", err_spurious, 1'b1);
    check("spur_cnt", done_cnt, exp_cnt);
    check("spur_no_req", intrp_req, 1'b0);
    intrp_ack = 1'b1; err_clr = 1'b1;
    step();
    intrp_ack = 1'b0;
    check("spur_clr_vs_err", err_spurious, 1'b1);
    step();
    err_clr = 1'b0;
    check("spur_clr", err_spurious, 1'b0);

    // Completion counter wrap
    while (exp_cnt != 4'd15) grant_ack(2);
    check("cnt_max", done_cnt, 4'd15);
    grant_ack(1);
    check("cnt_wrap", done_cnt, 4'd0);

    // Asynchronous reset in the middle of a request
    intrp_ack = 1'b1;
    step();
    intrp_ack = 1'b0;
    check("pre_rst_spur", err_spurious, 1'b1);
    ch_req = 4'b0100;
    step();
    ch_req = '0;
    wait_req();
    #2;
    rst = 1'b1;
    #1;
    check("rst_req", intrp_req, 1'b0);
    check("rst_busy", ch_busy, 4'b0);
    check("rst_err", {err_timeout, err_spurious}, 2'b0);
    check("rst_data", {intrp_src, 7'b0, intrp_ctx}, 80'b0);
    check("rst_cnt", done_cnt, 4'd0);
    #3;
    rst = 1'b0;
    step();
    check("post_rst_done", ch_done, 4'b0);
    ch_req = 4'b1001;
    step();
    ch_req = '0;
    step();
    check("post_rst_rr", {intrp_req, intrp_src}, {1'b1, src_of(0, 0)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
